// File: rtl/scanline_arbiter_pkg.sv
// Video timing constants and arbiter state encoding shared by the
// scanline arbiter and the display timing generator.
package scanline_arbiter_pkg;

   localparam int H_TOTAL = 800;
   localparam int V_TOTAL = 525;
   localparam int V_ADDR  = 480;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_VID  = 2'd1,
      ST_HOST = 2'd2
   } arb_state_t;

endpackage

// File: rtl/scanline_window.sv
// Decodes the beam position into the video-protected window, the
// vertical-blank start point and the last pixel of the frame.
module scanline_window
   import scanline_arbiter_pkg::*;
#(
   parameter int PREFETCH = 8
) (
   input  logic [9:0] i_hpos,
   input  logic [9:0] i_vpos,
   input  logic       i_display_on,
   output logic       o_prot,
   output logic       o_vblank_start,
   output logic       o_frame_end
);

   localparam logic [9:0] PF_START  = 10'(H_TOTAL - PREFETCH);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_PF_LAST = 10'(V_ADDR - 1);
   localparam logic [9:0] V_BLANK   = 10'(V_ADDR);

   logic w_prefetch_line;

   // Prefetch runs on every line whose successor is addressable, including
   // the final blanking line that precedes line 0.
   assign w_prefetch_line = (i_vpos < V_PF_LAST) || (i_vpos == V_LAST);
   assign o_prot          = i_display_on || ((i_hpos >= PF_START) && w_prefetch_line);
   assign o_vblank_start  = (i_hpos == 10'd0) && (i_vpos == V_BLANK);
   assign o_frame_end     = (i_hpos == H_LAST) && (i_vpos == V_LAST);

endmodule

// File: rtl/scanline_arbiter.sv
// Single-port frame-buffer arbiter: video owns the memory inside the
// protected window, the host gets it everywhere else.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no access on the memory bus this cycle
//   ST_VID  | video read on the memory bus this cycle
//   ST_HOST | host read or write on the memory bus this cycle
module scanline_arbiter
   import scanline_arbiter_pkg::*;
#(
   parameter int AW       = 10,
   parameter int DW       = 8,
   parameter int PREFETCH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [9:0]    hpos,
   input  logic [9:0]    vpos,
   input  logic          display_on,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_rdata,
   output logic          vid_rvalid,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          vblank_irq,
   output logic [7:0]    frame_cnt
);

   logic          w_prot;
   logic          w_vblank_start;
   logic          w_frame_end;
   logic          w_host_grant;
   logic          w_vid_grant;

   arb_state_t    r_state;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_vid_rvalid;
   logic          r_host_rvalid;
   logic [DW-1:0] r_vid_rdata;
   logic [DW-1:0] r_host_rdata;
   logic          r_vblank_irq;
   logic [7:0]    r_frame_cnt;

   scanline_window #(
      .PREFETCH (PREFETCH)
   ) u_window (
      .i_hpos         (hpos),
      .i_vpos         (vpos),
      .i_display_on   (display_on),
      .o_prot         (w_prot),
      .o_vblank_start (w_vblank_start),
      .o_frame_end    (w_frame_end)
   );

   // Outside the window a pending host request pre-empts (and drops) video.
   assign w_host_grant = !w_prot && host_valid;
   assign w_vid_grant  = vid_req && !w_host_grant;
   assign host_ready   = w_host_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_vid_rvalid  <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_vid_rdata   <= '0;
         r_host_rdata  <= '0;
         r_vblank_irq  <= 1'b0;
         r_frame_cnt   <= '0;
      end else begin
         if (w_host_grant) begin
            r_state     <= ST_HOST;
            r_mem_we    <= host_we;
            r_mem_addr  <= host_addr;
            r_mem_wdata <= host_wdata;
         end else if (w_vid_grant) begin
            r_state    <= ST_VID;
            r_mem_we   <= 1'b0;
            r_mem_addr <= vid_addr;
         end else begin
            r_state  <= ST_IDLE;
            r_mem_we <= 1'b0;
         end

         // Memory answers one cycle after the bus cycle.
         r_vid_rvalid  <= (r_state == ST_VID);
         r_host_rvalid <= (r_state == ST_HOST) && !r_mem_we;
         if (r_vid_rvalid)  r_vid_rdata  <= mem_rdata;
         if (r_host_rvalid) r_host_rdata <= mem_rdata;

         r_vblank_irq <= w_vblank_start;
         if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   assign mem_en      = (r_state != ST_IDLE);
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign vid_rvalid  = r_vid_rvalid;
   assign host_rvalid = r_host_rvalid;
   assign vid_rdata   = r_vid_rvalid  ? mem_rdata : r_vid_rdata;
   assign host_rdata  = r_host_rvalid ? mem_rdata : r_host_rdata;
   assign vblank_irq  = r_vblank_irq;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_scanline_arbiter.sv
// Scoreboard bench for scanline_arbiter: read results are queued with their
// expected data and return cycle, then popped as the rvalid pulses arrive.
module tb_scanline_arbiter;

   localparam int AW = 10;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [9:0]    hpos, vpos;
   logic          display_on;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_rdata;
   logic          vid_rvalid;
   logic          host_valid, host_ready, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          host_rvalid;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          vblank_irq;
   logic [7:0]    frame_cnt;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          vq[$];
   exp_t          hq[$];
   logic [DW-1:0] mem_arr [1024];
   logic [DW-1:0] shadow  [1024];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_err = 0;

   scanline_arbiter #(.AW(AW), .DW(DW), .PREFETCH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hpos        (hpos),
      .vpos        (vpos),
      .display_on  (display_on),
      .vid_req     (vid_req),
      .vid_addr    (vid_addr),
      .vid_rdata   (vid_rdata),
      .vid_rvalid  (vid_rvalid),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdata  (host_rdata),
      .host_rvalid (host_rvalid),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .vblank_irq  (vblank_irq),
      .frame_cnt   (frame_cnt)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAM, one cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic ref_prot(input logic [9:0] h, input logic [9:0] v, input logic don);
      return don || ((h >= 10'd792) && ((v < 10'd479) || (v == 10'd524)));
   endfunction

   task automatic set_pos(input int h, input int v);
      hpos       = 10'(h);
      vpos       = 10'(v);
      display_on = (h < 640) && (v < 480);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      vid_req = 1'b0;
      if (hpos == 10'd799) set_pos(0, (vpos == 10'd524) ? 0 : int'(vpos) + 1);
      else                 set_pos(int'(hpos) + 1, int'(vpos));
   endtask

   // Scoreboard drain: every rvalid must match the oldest expected read.
   always @(negedge clk) begin
      if (rst_n) begin
         if (vq.size() > 0 && vq[0].cyc < cyc) begin
            chk("vid_missing", 0, 1);
            void'(vq.pop_front());
         end
         if (hq.size() > 0 && hq[0].cyc < cyc) begin
            chk("host_missing", 0, 1);
            void'(hq.pop_front());
         end
         if (vid_rvalid) begin
            if (vq.size() == 0) chk("vid_unexpected", 1, 0);
            else begin
               exp_t e;
               e = vq.pop_front();
               chk("vid_rdata", vid_rdata, e.data);
               chk("vid_latency", cyc, e.cyc);
            end
         end
         if (host_rvalid) begin
            if (hq.size() == 0) chk("host_unexpected", 1, 0);
            else begin
               exp_t e;
               e = hq.pop_front();
               chk("host_rdata", host_rdata, e.data);
               chk("host_latency", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      logic g;
      int   irq_cnt;
      exp_t e;

      for (int i = 0; i < 1024; i++) begin
         mem_arr[i] = 8'(i) ^ 8'h5A;
         shadow[i]  = 8'(i) ^ 8'h5A;
      end
      rst_n = 1'b0;
      set_pos(0, 0);
      vid_req = 0; vid_addr = '0;
      host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;

      @(posedge clk); @(posedge clk); #1;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_vid_rvalid", vid_rvalid, 0);
      chk("rst_host_rdata", host_rdata, 0);
      rst_n = 1'b1;

      // Active area: video read, host blocked in the same cycle
      tick(); set_pos(100, 10);
      vid_req = 1; vid_addr = 10'h155;
      host_valid = 1; host_we = 1; host_addr = 10'h077; host_wdata = 8'hEE;
      #1 chk("ready_in_prot", host_ready, 0);
      e.data = shadow[10'h155]; e.cyc = cyc + 2; vq.push_back(e);
      tick(); host_valid = 0;
      chk("vid_mem_en", mem_en, 1);
      chk("vid_mem_addr", mem_addr, 10'h155);
      chk("vid_mem_we", mem_we, 0);
      tick(); tick();
      chk("vid_rdata_hold", vid_rdata, shadow[10'h155]);

      // Host write held across the end of the line
      tick(); set_pos(600, 10);
      host_valid = 1; host_we = 1; host_addr = 10'h02A; host_wdata = 8'h3C;
      for (int i = 0; i < 196; i++) begin
         g = !ref_prot(hpos, vpos, display_on);
         #1 chk("host_ready_line", host_ready, g);
         if (g) shadow[10'h02A] = 8'h3C;
         tick();
         chk("host_mem_en", mem_en, g);
         if (hpos == 10'd641) begin
            chk("host_mem_we", mem_we, 1);
            chk("host_mem_addr", mem_addr, 10'h02A);
            chk("host_mem_wdata", mem_wdata, 8'h3C);
         end
      end
      host_valid = 0;

      // Blanking: host read beats a simultaneous video request
      tick(); set_pos(100, 490);
      vid_req = 1; vid_addr = 10'h010;
      host_valid = 1; host_we = 0; host_addr = 10'h02A;
      #1 chk("ready_blank", host_ready, 1);
      e.data = shadow[10'h02A]; e.cyc = cyc + 2; hq.push_back(e);
      tick(); host_valid = 0;
      chk("hrd_mem_en", mem_en, 1);
      chk("hrd_mem_we", mem_we, 0);
      chk("hrd_mem_addr", mem_addr, 10'h02A);
      tick(); tick();
      chk("host_rdata_hold", host_rdata, 8'h3C);

      // Host read in flight when the prefetch window opens
      tick(); set_pos(791, 10);
      host_valid = 1; host_we = 0; host_addr = 10'h155;
      #1 chk("ready_791", host_ready, 1);
      e.data = shadow[10'h155]; e.cyc = cyc + 2; hq.push_back(e);
      tick(); host_valid = 0;
      vid_req = 1; vid_addr = 10'h02A;
      #1 chk("ready_792", host_ready, 0);
      e.data = shadow[10'h02A]; e.cyc = cyc + 2; vq.push_back(e);
      tick(); tick(); tick();

      // Vertical blank interrupt
      tick(); set_pos(797, 479);
      irq_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (vblank_irq) irq_cnt++;
         if (hpos == 10'd1 && vpos == 10'd480) chk("vblank_at", vblank_irq, 1);
      end
      chk("vblank_count", irq_cnt, 1);

      // Frame counter increment and wrap
      tick(); set_pos(798, 524);
      tick();
      chk("frame_before", frame_cnt, 0);
      tick();
      chk("frame_after", frame_cnt, 1);
      for (int k = 1; k < 256; k++) begin
         set_pos(799, 524);
         tick();
         chk("frame_cnt", frame_cnt, 32'((k + 1) % 256));
      end

      // Reset during an outstanding host read
      tick(); set_pos(100, 490);
      host_valid = 1; host_we = 0; host_addr = 10'h02A;
      tick(); host_valid = 0;
      chk("pre_rst_mem_en", mem_en, 1);
      rst_n = 1'b0;
      #1;
      chk("rst2_mem_en", mem_en, 0);
      chk("rst2_mem_we", mem_we, 0);
      chk("rst2_mem_addr", mem_addr, 0);
      chk("rst2_mem_wdata", mem_wdata, 0);
      chk("rst2_host_rvalid", host_rvalid, 0);
      chk("rst2_vid_rvalid", vid_rvalid, 0);
      chk("rst2_host_rdata", host_rdata, 0);
      chk("rst2_vid_rdata", vid_rdata, 0);
      chk("rst2_vblank", vblank_irq, 0);
      chk("rst2_frame_cnt", frame_cnt, 0);
      tick(); tick();
      rst_n = 1'b1;
      set_pos(5, 5);
      vid_req = 1; vid_addr = 10'h155;
      e.data = shadow[10'h155]; e.cyc = cyc + 2; vq.push_back(e);
      tick();
      chk("post_rst_mem_en", mem_en, 1);
      for (int i = 0; i < 5; i++) tick();

      chk("vq_empty", vq.size(), 0);
      chk("hq_empty", hq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
